// File: rtl/axi4_lite_pkg.sv
// rtl/axi4_lite_pkg.sv - shared types and register map for the AXI4-Lite counter slave
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_e;

    localparam logic [3:0] CTRL_OFS    = 4'h0;
    localparam logic [3:0] SCRATCH_OFS = 4'h4;
    localparam logic [3:0] COUNT_OFS   = 4'h8;
    localparam logic [3:0] STATUS_OFS  = 4'hC;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_CLR_BIT = 1;

    function automatic logic addr_aligned(input logic [3:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/ctr_slave_counter.sv
// rtl/ctr_slave_counter.sv - 32-bit free-running counter with enable and priority clear
module ctr_slave_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        clr,
    output logic [31:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 32'h0;
        end else if (clr) begin
            count <= 32'h0;
        end else if (en) begin
            count <= count + 32'h1;
        end
    end

endmodule

// File: rtl/axi4_lite_ctr_slave.sv
// rtl/axi4_lite_ctr_slave.sv - AXI4-Lite responder with CTRL/SCRATCH/COUNT/STATUS registers
module axi4_lite_ctr_slave
    import axi4_lite_pkg::*;
#(
    parameter logic [31:0] CTRL_RST    = 32'h0,
    parameter logic [31:0] SCRATCH_RST = 32'h0
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic [3:0]  AWADDR,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [31:0] WDATA,
    input  logic        WVALID,
    output logic        WREADY,
    output logic [1:0]  BRESP,
    output logic        BVALID,
    input  logic        BREADY,
    input  logic [3:0]  ARADDR,
    input  logic        ARVALID,
    output logic        ARREADY,
    output logic [31:0] RDATA,
    output logic [1:0]  RRESP,
    output logic        RVALID,
    input  logic        RREADY
);

    logic        aw_hold, w_hold;
    logic [3:0]  aw_addr_q;
    logic [31:0] w_data_q;
    logic [31:0] ctrl_q, scratch_q, count;
    logic [15:0] ok_cnt, err_cnt;

    logic        aw_hs, w_hs, ar_hs, commit, wr_err, cnt_clr;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data, rd_data;
    resp_e       rd_resp;

    assign AWREADY = !aw_hold && !BVALID;
    assign WREADY  = !w_hold && !BVALID;
    assign ARREADY = !RVALID;

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID && WREADY;
    assign ar_hs = ARVALID && ARREADY;

    // A channel counts as available when held or handshaking on this edge.
    always_comb begin
        wr_addr = aw_hold ? aw_addr_q : AWADDR;
        wr_data = w_hold ? w_data_q : WDATA;
        commit  = (aw_hold || aw_hs) && (w_hold || w_hs);
        wr_err  = !addr_aligned(wr_addr) || wr_addr == COUNT_OFS || wr_addr == STATUS_OFS;
        cnt_clr = commit && !wr_err && wr_addr == CTRL_OFS && wr_data[CTRL_CLR_BIT];
    end

    always_comb begin
        rd_data = 32'h0;
        rd_resp = RESP_OKAY;
        if (!addr_aligned(ARADDR)) begin
            rd_resp = RESP_SLVERR;
        end else begin
            case (ARADDR)
                CTRL_OFS:    rd_data = ctrl_q;
                SCRATCH_OFS: rd_data = scratch_q;
                COUNT_OFS:   rd_data = count;
                default:     rd_data = {err_cnt, ok_cnt};
            endcase
        end
    end

    ctr_slave_counter u_counter (
        .clk   (ACLK),
        .rst_n (ARESETn),
        .en    (ctrl_q[CTRL_EN_BIT]),
        .clr   (cnt_clr),
        .count (count)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            aw_hold   <= 1'b0;
            w_hold    <= 1'b0;
            aw_addr_q <= 4'h0;
            w_data_q  <= 32'h0;
            ctrl_q    <= CTRL_RST & ~32'h2;
            scratch_q <= SCRATCH_RST;
            ok_cnt    <= 16'h0;
            err_cnt   <= 16'h0;
            BVALID    <= 1'b0;
            BRESP     <= RESP_OKAY;
            RVALID    <= 1'b0;
            RDATA     <= 32'h0;
            RRESP     <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                aw_hold   <= 1'b1;
                aw_addr_q <= AWADDR;
            end
            if (w_hs) begin
                w_hold   <= 1'b1;
                w_data_q <= WDATA;
            end
            // Commit overrides the hold-set above when the second channel arrives.
            if (commit) begin
                aw_hold <= 1'b0;
                w_hold  <= 1'b0;
                BVALID  <= 1'b1;
                if (wr_err) begin
                    BRESP   <= RESP_SLVERR;
                    err_cnt <= err_cnt + 16'h1;
                end else begin
                    BRESP  <= RESP_OKAY;
                    ok_cnt <= ok_cnt + 16'h1;
                    if (wr_addr == CTRL_OFS)    ctrl_q    <= wr_data & ~32'h2;
                    if (wr_addr == SCRATCH_OFS) scratch_q <= wr_data;
                end
            end else if (BVALID && BREADY) begin
                BVALID <= 1'b0;
            end
            if (ar_hs) begin
                RVALID <= 1'b1;
                RDATA  <= rd_data;
                RRESP  <= rd_resp;
            end else if (RVALID && RREADY) begin
                RVALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi4_lite_ctr_slave.sv
// tb/tb_axi4_lite_ctr_slave.sv - directed vector bench for axi4_lite_ctr_slave
module tb_axi4_lite_ctr_slave;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [3:0]  AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [3:0]  ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;

    localparam logic [1:0] OK  = 2'b00;
    localparam logic [1:0] ERR = 2'b10;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [1:0]  resp;
    } vec_t;

    vec_t vecs[$];

    always #5 ACLK = ~ACLK;

    axi4_lite_ctr_slave dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .AWADDR  (AWADDR),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .WDATA   (WDATA),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .BRESP   (BRESP),
        .BVALID  (BVALID),
        .BREADY  (BREADY),
        .ARADDR  (ARADDR),
        .ARVALID (ARVALID),
        .ARREADY (ARREADY),
        .RDATA   (RDATA),
        .RRESP   (RRESP),
        .RVALID  (RVALID),
        .RREADY  (RREADY)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d, output logic [1:0] resp);
        int n = 0;
        AWADDR  = a;
        WDATA   = d;
        AWVALID = 1'b1;
        WVALID  = 1'b1;
        while (!(AWREADY && WREADY) && n < 20) begin
            tick();
            n++;
        end
        check("write_ready_wait", 32'(n < 20), 32'h1);
        tick();
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        check("bvalid_rise", 32'(BVALID), 32'h1);
        resp   = BRESP;
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        check("bvalid_drop", 32'(BVALID), 32'h0);
    endtask

    task automatic do_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n = 0;
        ARADDR  = a;
        ARVALID = 1'b1;
        while (!ARREADY && n < 20) begin
            tick();
            n++;
        end
        check("read_ready_wait", 32'(n < 20), 32'h1);
        tick();
        ARVALID = 1'b0;
        check("rvalid_rise", 32'(RVALID), 32'h1);
        d      = RDATA;
        resp   = RRESP;
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
        check("rvalid_drop", 32'(RVALID), 32'h0);
    endtask

    task automatic add(input bit wr, input logic [3:0] a, input logic [31:0] d, input logic [1:0] r);
        vec_t v;
        v.wr = wr; v.addr = a; v.data = d; v.resp = r;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d, d1, d2;
        logic [1:0]  r;

        ARESETn = 1'b0;
        AWADDR = 4'h0; AWVALID = 1'b0; WDATA = 32'h0; WVALID = 1'b0; BREADY = 1'b0;
        ARADDR = 4'h0; ARVALID = 1'b0; RREADY = 1'b0;
        tick();
        check("rst_bvalid", 32'(BVALID), 32'h0);
        check("rst_rvalid", 32'(RVALID), 32'h0);
        check("rst_bresp", 32'(BRESP), 32'h0);
        check("rst_rresp", 32'(RRESP), 32'h0);
        check("rst_rdata", RDATA, 32'h0);
        check("rst_readies", {29'h0, AWREADY, WREADY, ARREADY}, 32'h7);
        tick();
        ARESETn = 1'b1;
        tick();

        // wr, addr, write data / expected read data, expected response
        add(1, 4'h4, 32'hA5A5_5A5A, OK);
        add(0, 4'h4, 32'hA5A5_5A5A, OK);
        add(0, 4'hC, 32'h0000_0001, OK);
        add(0, 4'h0, 32'h0000_0000, OK);
        add(1, 4'h0, 32'hFFFF_FFFC, OK);
        add(0, 4'h0, 32'hFFFF_FFFC, OK);
        add(1, 4'h0, 32'h0000_0006, OK);
        add(0, 4'h0, 32'h0000_0004, OK);
        add(0, 4'h8, 32'h0000_0000, OK);
        add(1, 4'hC, 32'h0000_1234, ERR);
        add(1, 4'h6, 32'h0000_0000, ERR);
        add(0, 4'h5, 32'h0000_0000, ERR);
        add(0, 4'hC, 32'h0002_0003, OK);
        add(0, 4'h4, 32'hA5A5_5A5A, OK);
        add(1, 4'h0, 32'h0000_0000, OK);
        add(0, 4'h0, 32'h0000_0000, OK);

        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].data, r);
                check($sformatf("vec%0d_bresp", i), 32'(r), 32'(vecs[i].resp));
            end else begin
                do_read(vecs[i].addr, d, r);
                check($sformatf("vec%0d_rresp", i), 32'(r), 32'(vecs[i].resp));
                check($sformatf("vec%0d_rdata", i), d, vecs[i].data);
            end
        end

        // W two cycles ahead of AW
        WDATA = 32'h0000_1234; WVALID = 1'b1;
        tick();
        WVALID = 1'b0;
        check("split_wready_low", 32'(WREADY), 32'h0);
        check("split_bvalid_early", 32'(BVALID), 32'h0);
        tick();
        check("split_bvalid_wait", 32'(BVALID), 32'h0);
        check("split_awready", 32'(AWREADY), 32'h1);
        AWADDR = 4'h4; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        check("split_bvalid_rise", 32'(BVALID), 32'h1);
        check("split_bresp", 32'(BRESP), 32'(OK));
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        do_read(4'h4, d, r);
        check("split_readback", d, 32'h0000_1234);

        // Counter run, then clear
        do_write(4'h0, 32'h1, r);
        repeat (8) tick();
        do_read(4'h8, d1, r);
        check("count_range", 32'(d1 >= 9 && d1 <= 11), 32'h1);
        do_read(4'h8, d2, r);
        check("count_monotonic", 32'(d2 > d1), 32'h1);
        do_write(4'h0, 32'h3, r);
        do_read(4'h8, d, r);
        check("count_cleared", 32'(d <= 2), 32'h1);
        do_read(4'h0, d, r);
        check("ctrl_clr_selfclear", d, 32'h1);

        // Error write to COUNT leaves it untouched
        do_write(4'h0, 32'h0, r);
        do_read(4'h8, d1, r);
        do_write(4'h8, 32'h0000_FFFF, r);
        check("count_wr_bresp", 32'(r), 32'(ERR));
        do_read(4'h8, d2, r);
        check("count_unchanged", d2, d1);
        do_read(4'h5, d, r);
        check("unaligned_rresp", 32'(r), 32'(ERR));
        check("unaligned_rdata", d, 32'h0);
        do_read(4'hC, d, r);
        check("status_counts", d, 32'h0003_0008);

        // Backpressure with concurrent read and write of SCRATCH
        AWADDR = 4'h4; WDATA = 32'hDEAD_BEEF; AWVALID = 1'b1; WVALID = 1'b1;
        ARADDR = 4'h4; ARVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check("bp_bvalid", 32'(BVALID), 32'h1);
            check("bp_bresp", 32'(BRESP), 32'(OK));
            check("bp_rvalid", 32'(RVALID), 32'h1);
            check("bp_rdata_old", RDATA, 32'h0000_1234);
            check("bp_readies", {29'h0, AWREADY, WREADY, ARREADY}, 32'h0);
            tick();
        end
        BREADY = 1'b1; RREADY = 1'b1;
        tick();
        BREADY = 1'b0; RREADY = 1'b0;
        check("bp_bvalid_done", 32'(BVALID), 32'h0);
        check("bp_rvalid_done", 32'(RVALID), 32'h0);
        do_read(4'h4, d, r);
        check("bp_new_scratch", d, 32'hDEAD_BEEF);

        // Reset with AW held and a read response pending
        AWADDR = 4'h4; AWVALID = 1'b1; ARADDR = 4'h0; ARVALID = 1'b1;
        tick();
        AWVALID = 1'b0; ARVALID = 1'b0;
        check("mid_aw_held", 32'(AWREADY), 32'h0);
        check("mid_rvalid", 32'(RVALID), 32'h1);
        ARESETn = 1'b0;
        #1;
        check("mid_rst_valids", {30'h0, BVALID, RVALID}, 32'h0);
        check("mid_rst_readies", {29'h0, AWREADY, WREADY, ARREADY}, 32'h7);
        WDATA = 32'h5555_AAAA;
        tick();
        ARESETn = 1'b1;
        tick();
        do_read(4'h4, d, r);
        check("mid_scratch_rst", d, 32'h0);
        do_read(4'hC, d, r);
        check("mid_status_rst", d, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
